// File: rtl/uart_rx_gen2_if.sv
// Serial line, frame configuration and result pulses of the uart_rx_gen2 receiver.
// The slave modport is the receiver side; master is the stimulus/consumer side.
interface uart_rx_gen2_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
);
  logic                  RX_IN;
  logic [PRESCALE_W-1:0] prescale;
  logic                  parity_enable;
  logic                  parity_type;
  logic                  two_stop;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  data_valid;
  logic                  parity_error;
  logic                  stop_error;
  logic                  start_glitch;

  modport master (
    output RX_IN, prescale, parity_enable, parity_type, two_stop,
    input  P_DATA, data_valid, parity_error, stop_error, start_glitch
  );

  modport slave (
    input  RX_IN, prescale, parity_enable, parity_type, two_stop,
    output P_DATA, data_valid, parity_error, stop_error, start_glitch
  );
endinterface

// File: rtl/uart_rx_gen2.sv
// Oversampling UART receiver: 2-of-3 majority per bit, optional parity, one or two stop bits.
// Define UART_RX_SYNC_EN to pass RX_IN through a 2-flop synchroniser (adds 2 cycles of latency).
module uart_rx_gen2 #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic          clk,
  input  logic          rstn,
  uart_rx_gen2_if.slave bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] OUTPUT = 3'd5;

  localparam logic [PRESCALE_W-1:0] ONE      = PRESCALE_W'(1);
  localparam logic [3:0]            LAST_BIT = 4'(DATA_WIDTH - 1);

  logic                  rx;
  logic [2:0]            state_q, state_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [3:0]            bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic [2:0]            samp_q, samp_d;
  logic                  pe_q, pe_d, pt_q, pt_d, ts_q, ts_d;
  logic                  par_q, par_d, perr_q, perr_d, serr_q, serr_d;

  logic [PRESCALE_W-1:0] half, half_m1, half_p1;
  logic                  last_edge, third, vote, start_frame;

  assign half      = presc_q >> 1;
  assign half_m1   = half - ONE;
  assign half_p1   = half + ONE;
  assign last_edge = (cnt_q == presc_q - ONE);

  // The third sample may fall on the last edge (prescale=4), so use the live line then.
  assign third = (cnt_q == half_p1) ? rx : samp_q[2];
  assign vote  = (samp_q[0] & samp_q[1]) | (samp_q[0] & third) | (samp_q[1] & third);

  always_comb begin
    samp_d = samp_q;
    if (cnt_q == half_m1) samp_d[0] = rx;
    if (cnt_q == half)    samp_d[1] = rx;
    if (cnt_q == half_p1) samp_d[2] = rx;
  end

  always_comb begin
    // NOTE: every variable gets a default first, so no path through the case infers a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    presc_d     = presc_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    p_data_d    = p_data_q;
    pe_d        = pe_q;
    pt_d        = pt_q;
    ts_d        = ts_q;
    par_d       = par_q;
    perr_d      = perr_q;
    serr_d      = serr_q;
    start_frame = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx) start_frame = 1'b1;
      end
      START: begin
        cnt_d = last_edge ? '0 : cnt_q + ONE;
        if (last_edge) begin
          bit_d   = '0;
          state_d = vote ? IDLE : DATA;
        end
      end
      DATA: begin
        cnt_d = last_edge ? '0 : cnt_q + ONE;
        if (last_edge) begin
          shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
          par_d   = par_q ^ vote;
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = pe_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      PARITY: begin
        cnt_d = last_edge ? '0 : cnt_q + ONE;
        if (last_edge) begin
          perr_d  = vote ^ par_q ^ pt_q;
          state_d = STOP;
        end
      end
      STOP: begin
        cnt_d = last_edge ? '0 : cnt_q + ONE;
        if (last_edge) begin
          if (!vote) serr_d = 1'b1;
          if (ts_q && bit_q == 4'd0) begin
            bit_d = 4'd1;
          end else begin
            state_d = OUTPUT;
            if (!perr_q && !serr_q && vote) p_data_d = shift_q;
          end
        end
      end
      OUTPUT: begin
        cnt_d   = '0;
        state_d = IDLE;
        if (!rx) start_frame = 1'b1;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // The detection cycle is edge 0 of the start bit, so START begins at edge count 1.
    if (start_frame) begin
      state_d = START;
      cnt_d   = ONE;
      presc_d = bus.prescale;
      pe_d    = bus.parity_enable;
      pt_d    = bus.parity_type;
      ts_d    = bus.two_stop;
      par_d   = 1'b0;
      perr_d  = 1'b0;
      serr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      presc_q  <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      p_data_q <= '0;
      samp_q   <= '0;
      pe_q     <= 1'b0;
      pt_q     <= 1'b0;
      ts_q     <= 1'b0;
      par_q    <= 1'b0;
      perr_q   <= 1'b0;
      serr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      presc_q  <= presc_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      p_data_q <= p_data_d;
      samp_q   <= samp_d;
      pe_q     <= pe_d;
      pt_q     <= pt_d;
      ts_q     <= ts_d;
      par_q    <= par_d;
      perr_q   <= perr_d;
      serr_q   <= serr_d;
    end
  end

  // Pulses decode the registered state, so illegal encodings yield no pulse.
  assign bus.P_DATA       = p_data_q;
  assign bus.data_valid   = (state_q == OUTPUT) && !perr_q && !serr_q;
  assign bus.parity_error = (state_q == OUTPUT) && perr_q;
  assign bus.stop_error   = (state_q == OUTPUT) && serr_q;
  assign bus.start_glitch = (state_q == START) && last_edge && vote;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q, sync_d;

  assign sync_d = {sync_q[0], bus.RX_IN};
  assign rx     = sync_q[1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_q <= 2'b11;
    else       sync_q <= sync_d;
  end
`else
  assign rx = bus.RX_IN;
`endif

endmodule

// File: tb/tb_uart_rx_gen2.sv
// Directed bench for uart_rx_gen2: the line is driven one level per clock from a wave queue,
// and "cycle n" is the interval sampled by the n-th rising edge after the start-detection edge.
module tb_uart_rx_gen2;

  localparam int DW = 8;
  localparam int PW = 6;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  uart_rx_gen2_if #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) bus ();

  uart_rx_gen2 #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  bit wave[$];

  int       dv_n, dv_first, dv_second, pe_n, pe_first, se_n, se_first, sg_n, sg_first;
  logic [7:0] pd_first, pd_second, rst_pd;
  logic [3:0] rst_fl;

  task automatic add_level(input bit b, input int n);
    for (int k = 0; k < n; k++) wave.push_back(b);
  endtask

  task automatic add_frame(input logic [7:0] d, input int p, input bit has_par, input bit par_bit,
                           input bit ts, input bit stop1, input bit stop2);
    add_level(1'b0, p);
    for (int k = 0; k < 8; k++) add_level(d[k], p);
    if (has_par) add_level(par_bit, p);
    add_level(stop1, p);
    if (ts) add_level(stop2, p);
  endtask

  task automatic set_cfg(input int p, input bit pe, input bit pt, input bit ts);
    bus.prescale      = PW'(p);
    bus.parity_enable = pe;
    bus.parity_type   = pt;
    bus.two_stop      = ts;
  endtask

  // Plays the queued wave; index i is sampled before edge i and then driven for edge i.
  task automatic run_wave(input int rst_at, input int chg_at);
    dv_n = 0; pe_n = 0; se_n = 0; sg_n = 0;
    dv_first = -1; dv_second = -1; pe_first = -1; se_first = -1; sg_first = -1;
    pd_first = 'x; pd_second = 'x; rst_pd = 'x; rst_fl = 'x;
    for (int i = 0; i < wave.size(); i++) begin
      @(negedge clk);
      if (bus.data_valid === 1'b1) begin
        if (dv_n == 0) begin dv_first = i; pd_first = bus.P_DATA; end
        else if (dv_n == 1) begin dv_second = i; pd_second = bus.P_DATA; end
        dv_n++;
      end
      if (bus.parity_error === 1'b1) begin if (pe_n == 0) pe_first = i; pe_n++; end
      if (bus.stop_error === 1'b1)   begin if (se_n == 0) se_first = i; se_n++; end
      if (bus.start_glitch === 1'b1) begin if (sg_n == 0) sg_first = i; sg_n++; end
      if (rst_at >= 0 && i == rst_at + 1) begin
        rst_pd = bus.P_DATA;
        rst_fl = {bus.data_valid, bus.parity_error, bus.stop_error, bus.start_glitch};
      end
      if (i == rst_at) rstn = 1'b0;
      if (rst_at >= 0 && i == rst_at + 3) rstn = 1'b1;
      if (i == chg_at) set_cfg(12, 1'b1, 1'b1, 1'b1);
      bus.RX_IN = wave[i];
    end
    wave.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (bus.P_DATA !== 8'h00) begin
      failures++; $display("FAIL reset_pdata: got %h expected 00", bus.P_DATA);
    end
    checks++;
    if ({bus.data_valid, bus.parity_error, bus.stop_error, bus.start_glitch} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_pulses: got %b expected 0000",
               {bus.data_valid, bus.parity_error, bus.stop_error, bus.start_glitch});
    end
    rstn = 1'b1;
    add_level(1'b1, 10);
    run_wave(-1, -1);
    checks++;
    if (dv_n + pe_n + se_n + sg_n !== 0) begin
      failures++; $display("FAIL idle_after_reset_pulses: got %0d expected 0", dv_n + pe_n + se_n + sg_n);
    end
  endtask

  // 8N1 0xA5 at prescale 8; config is scrambled mid-frame and must be ignored.
  task automatic test_8n1();
    set_cfg(8, 1'b0, 1'b0, 1'b0);
    add_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    add_level(1'b1, 20);
    run_wave(-1, 30);
    checks++;
    if (dv_first !== 80) begin failures++; $display("FAIL 8n1_dv_cycle: got %0d expected 80", dv_first); end
    checks++;
    if (dv_n !== 1) begin failures++; $display("FAIL 8n1_dv_count: got %0d expected 1", dv_n); end
    checks++;
    if (pd_first !== 8'hA5) begin failures++; $display("FAIL 8n1_pdata: got %h expected a5", pd_first); end
    checks++;
    if (pe_n + se_n + sg_n !== 0) begin
      failures++; $display("FAIL 8n1_err_pulses: got %0d expected 0", pe_n + se_n + sg_n);
    end
  endtask

  // 0x3C has even weight, so even parity expects 0; sending 1 is an error at 11*16=176.
  task automatic test_parity_error();
    set_cfg(16, 1'b1, 1'b0, 1'b0);
    add_frame(8'h3C, 16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    add_level(1'b1, 20);
    run_wave(-1, -1);
    checks++;
    if (pe_first !== 176) begin failures++; $display("FAIL par_err_cycle: got %0d expected 176", pe_first); end
    checks++;
    if (dv_n !== 0) begin failures++; $display("FAIL par_err_dv_count: got %0d expected 0", dv_n); end
    checks++;
    if (bus.P_DATA !== 8'hA5) begin failures++; $display("FAIL par_err_pdata_hold: got %h expected a5", bus.P_DATA); end
    checks++;
    if (se_n !== 0) begin failures++; $display("FAIL par_err_stop_pulse: got %0d expected 0", se_n); end
  endtask

  // Odd parity on 0x3C expects 1: good frame, data_valid at 11*8=88.
  task automatic test_parity_odd();
    set_cfg(8, 1'b1, 1'b1, 1'b0);
    add_frame(8'h3C, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    add_level(1'b1, 20);
    run_wave(-1, -1);
    checks++;
    if (dv_first !== 88) begin failures++; $display("FAIL par_odd_dv_cycle: got %0d expected 88", dv_first); end
    checks++;
    if (pd_first !== 8'h3C) begin failures++; $display("FAIL par_odd_pdata: got %h expected 3c", pd_first); end
    checks++;
    if (pe_n !== 0) begin failures++; $display("FAIL par_odd_pe_pulse: got %0d expected 0", pe_n); end
  endtask

  // Three low cycles then high: rejected at cycle 7; a frame at cycle 10 proves the FSM idled.
  task automatic test_glitch();
    set_cfg(8, 1'b0, 1'b0, 1'b0);
    add_level(1'b0, 3);
    add_level(1'b1, 7);
    add_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    add_level(1'b1, 20);
    run_wave(-1, -1);
    checks++;
    if (sg_first !== 7) begin failures++; $display("FAIL glitch_cycle: got %0d expected 7", sg_first); end
    checks++;
    if (sg_n !== 1) begin failures++; $display("FAIL glitch_count: got %0d expected 1", sg_n); end
    checks++;
    if (dv_first !== 90) begin failures++; $display("FAIL glitch_next_dv_cycle: got %0d expected 90", dv_first); end
    checks++;
    if (pd_first !== 8'h5A) begin failures++; $display("FAIL glitch_next_pdata: got %h expected 5a", pd_first); end
  endtask

  // Two stop bits, second one 0: stop_error at 11*8=88; then a good 2-stop frame from cycle 100.
  task automatic test_two_stop();
    set_cfg(8, 1'b0, 1'b0, 1'b1);
    add_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    add_level(1'b1, 12);
    add_frame(8'h7E, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    add_level(1'b1, 20);
    run_wave(-1, -1);
    checks++;
    if (se_first !== 88) begin failures++; $display("FAIL two_stop_err_cycle: got %0d expected 88", se_first); end
    checks++;
    if (se_n !== 1) begin failures++; $display("FAIL two_stop_err_count: got %0d expected 1", se_n); end
    checks++;
    if (dv_first !== 188) begin failures++; $display("FAIL two_stop_dv_cycle: got %0d expected 188", dv_first); end
    checks++;
    if (pd_first !== 8'h7E) begin failures++; $display("FAIL two_stop_pdata: got %h expected 7e", pd_first); end
    checks++;
    if (dv_n !== 1) begin failures++; $display("FAIL two_stop_dv_count: got %0d expected 1", dv_n); end
  endtask

  task automatic test_back_to_back();
    set_cfg(8, 1'b0, 1'b0, 1'b0);
    add_frame(8'h11, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    add_frame(8'h22, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    add_level(1'b1, 20);
    run_wave(-1, -1);
    checks++;
    if (dv_first !== 80) begin failures++; $display("FAIL b2b_dv1_cycle: got %0d expected 80", dv_first); end
    checks++;
    if (dv_second - dv_first !== 80) begin
      failures++; $display("FAIL b2b_dv_spacing: got %0d expected 80", dv_second - dv_first);
    end
    checks++;
    if (pd_first !== 8'h11) begin failures++; $display("FAIL b2b_pdata1: got %h expected 11", pd_first); end
    checks++;
    if (pd_second !== 8'h22) begin failures++; $display("FAIL b2b_pdata2: got %h expected 22", pd_second); end
    checks++;
    if (dv_n !== 2) begin failures++; $display("FAIL b2b_dv_count: got %0d expected 2", dv_n); end
  endtask

  // Reset lands in data bit 4 (cycles 40..47) of 0xC3; the next frame starts at cycle 60.
  task automatic test_midframe_reset();
    set_cfg(8, 1'b0, 1'b0, 1'b0);
    add_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    wave = wave[0:41];
    add_level(1'b1, 18);
    add_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    add_level(1'b1, 20);
    run_wave(42, -1);
    checks++;
    if (rst_pd !== 8'h00) begin failures++; $display("FAIL mid_reset_pdata: got %h expected 00", rst_pd); end
    checks++;
    if (rst_fl !== 4'b0000) begin failures++; $display("FAIL mid_reset_pulses: got %b expected 0000", rst_fl); end
    checks++;
    if (dv_first !== 140) begin failures++; $display("FAIL mid_reset_dv_cycle: got %0d expected 140", dv_first); end
    checks++;
    if (pd_first !== 8'h96) begin failures++; $display("FAIL mid_reset_pdata_next: got %h expected 96", pd_first); end
    checks++;
    if (dv_n + pe_n + se_n + sg_n !== 1) begin
      failures++; $display("FAIL mid_reset_pulse_total: got %0d expected 1", dv_n + pe_n + se_n + sg_n);
    end
  endtask

  initial begin
    bus.RX_IN = 1'b1;
    set_cfg(8, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_8n1();
    test_parity_error();
    test_parity_odd();
    test_glitch();
    test_two_stop();
    test_back_to_back();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_gen2.md
UART_RX_GEN2 -- requirements
Module: uart_rx_gen2

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data bits per frame, legal 5..9.
REQ-002 SHALL have parameter PRESCALE_W, default 6, width of the prescale input.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port RX_IN  input  1  serial line, idle high.
REQ-006 SHALL have port prescale  input  PRESCALE_W  clk cycles per bit, even, legal 4..2^PRESCALE_W-2.
REQ-007 SHALL have port parity_enable  input  1  parity bit present.
REQ-008 SHALL have port parity_type  input  1  0=even, 1=odd.
REQ-009 SHALL have port two_stop  input  1  1=two stop bits, 0=one.
REQ-010 SHALL have port P_DATA  output  DATA_WIDTH  last good received word.
REQ-011 SHALL have port data_valid  output  1  one-cycle pulse, good frame.
REQ-012 SHALL have port parity_error  output  1  one-cycle pulse, parity mismatch.
REQ-013 SHALL have port stop_error  output  1  one-cycle pulse, any stop bit sampled 0.
REQ-014 SHALL have port start_glitch  output  1  one-cycle pulse, start bit rejected.

Function
REQ-015 SHALL implement states IDLE, START, DATA, PARITY, STOP, OUTPUT; PARITY skipped when parity_enable=0.
REQ-016 SHALL latch prescale, parity_enable, parity_type, two_stop on start detection; changes mid-frame have no effect.
REQ-017 SHALL count edges 0..prescale-1 per bit; the IDLE cycle seeing rx=0 is edge 0 of the start bit; START is entered with edge count 1.
REQ-018 SHALL sample each bit at edges prescale/2-1, prescale/2, prescale/2+1 and take the 2-of-3 majority.
REQ-019 SHALL change state only at edge prescale-1.
REQ-020 SHALL, when the start majority is 1, pulse start_glitch at edge prescale-1 and return to IDLE.
REQ-021 SHALL shift data LSB-first, exactly DATA_WIDTH bits.
REQ-022 SHALL compute expected parity as XOR of data bits, inverted when parity_type=1.
REQ-023 SHALL check one stop bit, or two when two_stop=1; stop_error is set if either is 0.
REQ-024 SHALL spend exactly one cycle in OUTPUT, beginning the cycle after the last edge of the final stop bit.
REQ-025 SHALL in OUTPUT pulse data_valid and load P_DATA only when there is no parity or stop error; otherwise pulse the applicable error flags and leave P_DATA unchanged.
REQ-026 SHALL in OUTPUT treat rx=0 as edge 0 of a new start bit (next state START, edge count 1); otherwise go to IDLE.
REQ-027 SHALL place data_valid at cycle (1+DATA_WIDTH+parity_enable+1+two_stop)*prescale after the detection cycle, when no synchroniser is fitted.
REQ-028 SHALL decode illegal state encodings to IDLE with all pulses 0.

Reset
REQ-029 SHALL on rstn=0 asynchronously force IDLE, counters 0, P_DATA 0, data_valid/parity_error/stop_error/start_glitch 0.
REQ-030 SHALL, when reset is asserted mid-frame, discard the frame; after release, no pulse occurs until a new start bit is detected.

Configuration
REQ-031 SHALL, with macro UART_RX_SYNC_EN defined, pass RX_IN through a 2-flop synchroniser (reset value 1) before all logic, adding 2 cycles to every latency.
REQ-032 SHALL, without UART_RX_SYNC_EN, use RX_IN directly with the latencies of REQ-027.

Verification
REQ-033 SHALL test: prescale=8, 8N1, byte 0xA5 -> data_valid at cycle 80, P_DATA=0xA5, no error pulses.
REQ-034 SHALL test: prescale=16, parity even, byte 0x3C with parity bit 1 -> parity_error pulse, no data_valid, P_DATA holds previous value.
REQ-035 SHALL test: prescale=8, rx low for 3 cycles then high -> start_glitch at cycle 7, FSM in IDLE.
REQ-036 SHALL test: two_stop=1, second stop bit 0 -> stop_error pulse at cycle (1+8+2)*prescale.
REQ-037 SHALL test: back-to-back frames 0x11, 0x22 with no idle gap -> two data_valid pulses exactly 10*prescale cycles apart.
REQ-038 SHALL test: rstn asserted at data bit 4, then released -> all outputs 0 and the next full frame is received correctly.
